// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: divides the system clock to a pixel
// rate and produces sync/blank, pixel coordinates, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COORD_W   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic               vga_clk,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_nxt;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               x_wrap;
  logic               y_wrap;

  function automatic logic h_level(input logic [COORD_W-1:0] xv);
    if (xv >= COORD_W'(H_ACTIVE + H_FP) && xv < COORD_W'(H_ACTIVE + H_FP + H_SYNC))
      return HSYNC_POL;
    return ~HSYNC_POL;
  endfunction

  function automatic logic v_level(input logic [COORD_W-1:0] yv);
    if (yv >= COORD_W'(V_ACTIVE + V_FP) && yv < COORD_W'(V_ACTIVE + V_FP + V_SYNC))
      return VSYNC_POL;
    return ~VSYNC_POL;
  endfunction

  function automatic logic blank_level(input logic [COORD_W-1:0] xv,
                                       input logic [COORD_W-1:0] yv);
    return !(xv < COORD_W'(H_ACTIVE) && yv < COORD_W'(V_ACTIVE));
  endfunction

  always_comb begin
    pix_tick = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    div_nxt  = pix_tick ? '0 : div_cnt + DIV_W'(1);
    x_wrap   = (x == COORD_W'(H_TOTAL - 1));
    y_wrap   = (y == COORD_W'(V_TOTAL - 1));
    x_nxt    = x_wrap ? '0 : x + COORD_W'(1);
    y_nxt    = y;
    if (x_wrap)
      y_nxt = y_wrap ? '0 : y + COORD_W'(1);
  end

  // Sync and blank are decoded from the next coordinates so they land with x/y.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      vga_clk     <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        div_cnt <= div_nxt;
        vga_clk <= (div_nxt >= DIV_W'(CLK_DIV / 2));
      end
      if (pix_tick) begin
        x           <= x_nxt;
        y           <= y_nxt;
        hsync       <= h_level(x_nxt);
        vsync       <= v_level(y_nxt);
        blank       <= blank_level(x_nxt, y_nxt);
        line_start  <= x_wrap;
        frame_start <= x_wrap && y_wrap;
        if (x_wrap && y_wrap)
          frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven by one stimulus stream and
// compared every cycle against a pixel-count reference model.
module tb_vga_timing_gen;

  localparam int D = 2;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;

  int asserts = 0;
  int failures = 0;

  // reference model state: enabled clock count, pixel count, tick on last edge
  int e = 0;
  int n = 0;
  bit last_tick = 1'b0;

  logic       vc_a, pt_a, hs_a, vs_a, bl_a, ls_a, fs_a;
  logic [4:0] x_a, y_a;
  logic [7:0] fc_a;
  logic       vc_b, pt_b, hs_b, vs_b, bl_b, ls_b, fs_b;
  logic [2:0] x_b, y_b;
  logic [7:0] fc_b;
  logic       vc_c, pt_c, hs_c, vs_c, bl_c, ls_c, fs_c;
  logic [9:0] x_c, y_c;
  logic [7:0] fc_c;

  always #5 if (clk_run) clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .CLK_DIV(D), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COORD_W(5)) dut_a (
    .clock(clk), .reset(reset), .enable(enable), .vga_clk(vc_a), .pix_tick(pt_a),
    .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a));

  vga_timing_gen #(.H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .CLK_DIV(D), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(3)) dut_b (
    .clock(clk), .reset(reset), .enable(enable), .vga_clk(vc_b), .pix_tick(pt_b),
    .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b));

  vga_timing_gen dut_c (
    .clock(clk), .reset(reset), .enable(enable), .vga_clk(vc_c), .pix_tick(pt_c),
    .hsync(hs_c), .vsync(vs_c), .blank(bl_c), .x(x_c), .y(y_c),
    .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    asserts++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_dut(input string tag,
                           input int ha, input int hf, input int hsw, input int hb,
                           input int va, input int vf, input int vsw, input int vb,
                           input bit hp, input bit vp,
                           input logic pt, input logic vc, input logic hsy, input logic vsy,
                           input logic bl, input logic [31:0] xv, input logic [31:0] yv,
                           input logic ls, input logic fs, input logic [7:0] fc);
    int ht, vt, ph, xe, ye;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ph = e % D;
    xe = n % ht;
    ye = (n / ht) % vt;
    chk({tag, ".pix_tick"}, 32'(pt), 32'(enable && ph == D - 1));
    chk({tag, ".vga_clk"}, 32'(vc), 32'(ph >= D / 2));
    chk({tag, ".x"}, xv, 32'(xe));
    chk({tag, ".y"}, yv, 32'(ye));
    chk({tag, ".hsync"}, 32'(hsy),
        32'((xe >= ha + hf && xe < ha + hf + hsw) ? hp : !hp));
    chk({tag, ".vsync"}, 32'(vsy),
        32'((ye >= va + vf && ye < va + vf + vsw) ? vp : !vp));
    chk({tag, ".blank"}, 32'(bl), 32'(!(xe < ha && ye < va)));
    chk({tag, ".line_start"}, 32'(ls), 32'(last_tick && xe == 0));
    chk({tag, ".frame_start"}, 32'(fs), 32'(last_tick && xe == 0 && ye == 0));
    chk({tag, ".frame_count"}, 32'(fc), 32'((n / (ht * vt)) % 256));
  endtask

  task automatic check_all();
    check_dut("a", 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0,
              pt_a, vc_a, hs_a, vs_a, bl_a, 32'(x_a), 32'(y_a), ls_a, fs_a, fc_a);
    check_dut("b", 2, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1,
              pt_b, vc_b, hs_b, vs_b, bl_b, 32'(x_b), 32'(y_b), ls_b, fs_b, fc_b);
    check_dut("c", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
              pt_c, vc_c, hs_c, vs_c, bl_c, 32'(x_c), 32'(y_c), ls_c, fs_c, fc_c);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) begin
      if (enable) begin
        last_tick = (e % D == D - 1);
        e++;
        if (last_tick) n++;
      end else begin
        last_tick = 1'b0;
      end
    end
    #1;
    check_all();
  endtask

  task automatic model_reset();
    e = 0;
    n = 0;
    last_tick = 1'b0;
  endtask

  initial begin
    logic h0, v0;
    bit found;

    // reset with the clock stopped
    #2 reset = 1'b1;
    #2 model_reset();
    check_all();

    enable = 1'b1;
    clk_run = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("first_tick", 32'(pt_a), 32'd1);
    step();
    chk("first_x", 32'(x_a), 32'd1);

    for (int i = 0; i < 800; i++) step();
    chk("three_frames", 32'(fc_a), 32'(n / 128));

    // hold at x=5
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (n % 16 == 5 && last_tick) found = 1'b1;
    end
    chk("hold_found", 32'(found), 32'd1);
    enable = 1'b0;
    h0 = hs_a;
    v0 = vs_a;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_x", 32'(x_a), 32'd5);
      chk("hold_tick", 32'(pt_a), 32'd0);
      chk("hold_hsync", 32'(hs_a), 32'(h0));
      chk("hold_vsync", 32'(vs_a), 32'(v0));
    end
    enable = 1'b1;
    step();
    step();
    chk("resume_x", 32'(x_a), 32'd6);

    // random enable
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      step();
    end

    // mid-frame reset at y=3
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if ((n / 16) % 8 == 3) found = 1'b1;
    end
    chk("y3_found", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst_x", 32'(x_a), 32'd0);
    chk("rst_y", 32'(y_a), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rst_first_tick", 32'(pt_a), 32'd1);

    // run until dut_b has completed 256 frames
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      step();
      if (n == 256 * 25) found = 1'b1;
    end
    chk("fc_wrap_reached", 32'(found), 32'd1);
    chk("fc_wrap", 32'(fc_b), 32'd0);
    for (int i = 0; i < 60; i++) step();
    chk("fc_after_wrap", 32'(fc_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
